// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART receiver.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with first-word fall-through head register and push/pop/count.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] dout_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign do_push = push_i && (!full_o || do_pop);
    assign rd_nxt  = rd_ptr_q + AW'(1);
    assign dout_o  = dout_q;
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_nxt;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            // With one entry held, the next head is the byte being written right now.
            if (do_pop)
                dout_q <= (do_push && rd_nxt == wr_ptr_q) ? din_i : mem_q[rd_nxt];
            else if (do_push && empty_o)
                dout_q <= din_i;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Buffered UART receiver: 16x oversampling, mid-bit sampling, framing check, FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 27,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    input  logic             rd_en,
    output logic [7:0]       data_out,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             frame_err,
`ifdef UART_RX_PARITY_EN
    output logic             parity_err,
`endif
    output logic             overrun
);

    localparam int TICK_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    rx_state_e           state_q, state_d;
    logic                rx_meta_q, rx_s;
    logic [TICK_W-1:0]   tick_q;
    logic                os_tick;
    logic [3:0]          samp_q, samp_d;
    logic [2:0]          bidx_q, bidx_d;
    logic [7:0]          shift_q, shift_d;
    logic                armed_q, armed_d;
    logic                push;
    logic                ferr_d, ferr_q, ovr_q;
`ifdef UART_RX_PARITY_EN
    logic                par_q, par_d, perr_d, perr_q;
    assign parity_err = perr_q;
`endif

    assign os_tick   = (tick_q == TICK_W'(BAUD_DIV - 1));
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
            tick_q    <= '0;
            state_q   <= IDLE;
            samp_q    <= '0;
            bidx_q    <= '0;
            shift_q   <= '0;
            armed_q   <= 1'b1;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx;
            rx_s      <= rx_meta_q;
            tick_q    <= os_tick ? '0 : tick_q + TICK_W'(1);
            state_q   <= state_d;
            samp_q    <= samp_d;
            bidx_q    <= bidx_d;
            shift_q   <= shift_d;
            armed_q   <= armed_d;
            ferr_q    <= ferr_d;
            ovr_q     <= push && full && !rd_en;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        samp_d  = samp_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        armed_d = armed_q;
        push    = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // After a framing error the line must return high before a new start counts.
                if (rx_s) armed_d = 1'b1;
                else if (armed_q) begin
                    samp_d  = '0;
                    state_d = START;
                end
            end
            START: if (os_tick) begin
                if (samp_q == 4'(MID_SAMPLE)) begin
                    if (!rx_s) begin
                        samp_d  = '0;
                        bidx_d  = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    samp_d = samp_q + 4'd1;
                end
            end
            DATA: if (os_tick) begin
                samp_d = samp_q + 4'd1;
                if (samp_q == 4'(OVERSAMPLE - 1)) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    bidx_d  = bidx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bidx_q == 3'(DATA_BITS - 1)) state_d = PARITY;
`else
                    if (bidx_q == 3'(DATA_BITS - 1)) state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (os_tick) begin
                samp_d = samp_q + 4'd1;
                if (samp_q == 4'(OVERSAMPLE - 1)) begin
                    par_d   = rx_s;
                    state_d = STOP;
                end
            end
`endif
            STOP: if (os_tick) begin
                samp_d = samp_q + 4'd1;
                if (samp_q == 4'(OVERSAMPLE - 1)) begin
                    state_d = IDLE;
                    if (!rx_s) begin
                        ferr_d  = 1'b1;
                        armed_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                    end else if (^shift_q ^ par_q) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (shift_q),
        .pop_i   (rd_en),
        .dout_o  (data_out),
        .empty_o (empty),
        .full_o  (full),
        .count_o (count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed frames, decoupled monitor checks reads and status.
module tb_uart_rx_fifo;

    localparam int BAUD_DIV   = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 3;
    localparam int BIT_CLKS   = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rx = 1'b1;
    logic             rd_en = 1'b0;
    logic [7:0]       data_out;
    logic             empty, full, frame_err, overrun;
    logic [CNT_W-1:0] count;
`ifdef UART_RX_PARITY_EN
    logic             parity_err;
`endif

    always #5 clk = ~clk;

    uart_rx_fifo #(.BAUD_DIV(BAUD_DIV), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rd_en     (rd_en),
        .data_out  (data_out),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun   (overrun)
    );

    typedef struct {
        string name;
        int    cnt;
        int    emp;
        int    ful;
        int    head;   // -1: head not checked
        int    fe;
        int    ov;
        int    pe;
    } status_t;

    status_t          chk_q[$];
    byte unsigned     rd_exp_q[$];
    int               n_cmp = 0, n_bad = 0;
    int               fe_cycles = 0, ov_cycles = 0, pe_cycles = 0, tmo = 0;

    function automatic void cmp(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endfunction

    // Monitor: pulse widths, popped bytes and queued status expectations.
    always @(negedge clk) begin
        status_t s;
        byte unsigned e;
        if (frame_err) fe_cycles++;
        if (overrun)   ov_cycles++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) pe_cycles++;
`endif
        if (rd_en && !empty) begin
            if (rd_exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL read_unexpected: got 0x%02h, required no read data", data_out);
            end else begin
                e = rd_exp_q.pop_front();
                cmp("read_data", int'(data_out), int'(e));
            end
        end
        if (chk_q.size() != 0) begin
            s = chk_q.pop_front();
            cmp({s.name, ".count"}, int'(count), s.cnt);
            cmp({s.name, ".empty"}, int'(empty), s.emp);
            cmp({s.name, ".full"},  int'(full),  s.ful);
            if (s.head >= 0) cmp({s.name, ".data_out"}, int'(data_out), s.head);
            cmp({s.name, ".frame_err_cycles"}, fe_cycles, s.fe);
            cmp({s.name, ".overrun_cycles"},   ov_cycles, s.ov);
`ifdef UART_RX_PARITY_EN
            cmp({s.name, ".parity_err_cycles"}, pe_cycles, s.pe);
`endif
            cmp({s.name, ".timeouts"}, tmo, 0);
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stp, input logic par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par === 1'bx) rx = 1'b1;
`endif
        drive_bit(stp);
        rx = 1'b1;
    endtask

    task automatic status(input string nm, input int c, input int em, input int fu,
                          input int hd, input int fe, input int ov, input int pe);
        status_t s;
        s.name = nm; s.cnt = c; s.emp = em; s.ful = fu; s.head = hd;
        s.fe = fe; s.ov = ov; s.pe = pe;
        chk_q.push_back(s);
        wait_clks(2);
    endtask

    task automatic rd(input byte unsigned e);
        rd_exp_q.push_back(e);
        rd_en = 1'b1;
        wait_clks(1);
        rd_en = 1'b0;
        wait_clks(1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_clks(3);
        status("reset", 0, 1, 0, 0, 0, 0, 0);
        rst = 1'b0;
        wait_clks(5);

        send_frame(8'hA5, 1'b1, 1'b0);
        status("a5_rx", 1, 0, 0, 'hA5, 0, 0, 0);
        rd(8'hA5);
        status("a5_pop", 0, 1, 0, -1, 0, 0, 0);

        // Start-bit glitch: five oversample ticks low.
        rx = 1'b0;
        wait_clks(10);
        rx = 1'b1;
        wait_clks(40);
        status("glitch", 0, 1, 0, -1, 0, 0, 0);

        send_frame(8'h3C, 1'b0, 1'b0);
        wait_clks(40);
        status("ferr", 0, 1, 0, -1, 1, 0, 0);
        send_frame(8'h81, 1'b1, 1'b0);
        status("x81", 1, 0, 0, 'h81, 1, 0, 0);
        rd(8'h81);

        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1);
        status("ovr", 4, 0, 1, 'h01, 1, 1, 0);
        rd(8'h01); rd(8'h02); rd(8'h03); rd(8'h04);
        status("drain", 0, 1, 0, -1, 1, 1, 0);
        rd_en = 1'b1;
        wait_clks(1);
        rd_en = 1'b0;
        status("rd_empty", 0, 1, 0, -1, 1, 1, 0);

        send_frame(8'h10, 1'b1, 1'b1);
        send_frame(8'h20, 1'b1, 1'b1);
        send_frame(8'h30, 1'b1, 1'b0);
        send_frame(8'h40, 1'b1, 1'b1);
        status("refill", 4, 0, 1, 'h10, 1, 1, 0);
        fork
            send_frame(8'h77, 1'b1, 1'b0);
            begin
                bit hit;
                hit = 1'b0;
                for (int i = 0; i < 400 && !hit; i++) begin
                    @(posedge clk);
                    #1;
                    if (dut.push) begin
                        rd_exp_q.push_back(8'h10);
                        rd_en = 1'b1;
                        @(posedge clk);
                        #1;
                        rd_en = 1'b0;
                        hit = 1'b1;
                    end
                end
                if (!hit) begin
                    tmo++;
                    $display("FAIL push_window: no push within 400 cycles, required one");
                end
            end
        join
        status("full_pop", 4, 0, 1, 'h20, 1, 1, 0);
        rd(8'h20); rd(8'h30); rd(8'h40); rd(8'h77);
        status("full_pop_drain", 0, 1, 0, -1, 1, 1, 0);

        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        status("pre_rst", 2, 0, 0, 'h11, 1, 1, 0);
        // Partial 0x55 frame: start, bit0=1, half of bit1=0, then reset.
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx = 1'b0;
        wait_clks(16);
        rst = 1'b1;
        status("in_rst", 0, 1, 0, 0, 1, 1, 0);
        rx = 1'b1;
        rst = 1'b0;
        wait_clks(40);
        status("post_rst", 0, 1, 0, 0, 1, 1, 0);
        send_frame(8'h99, 1'b1, 1'b0);
        status("x99", 1, 0, 0, 'h99, 1, 1, 0);
        rd(8'h99);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        status("par_bad", 0, 1, 0, -1, 1, 1, 1);
        send_frame(8'h07, 1'b1, 1'b1);
        status("par_ok", 1, 0, 0, 'h07, 1, 1, 1);
        rd(8'h07);
`endif

        status("final", 0, 1, 0, -1, 1, 1, `ifdef UART_RX_PARITY_EN 1 `else 0 `endif);
        wait_clks(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Standalone buffered UART receiver, the far end of the serial link driven by the existing transmitter. It uses 16x oversampling with mid-bit sampling, checks framing, and pushes received bytes into a small synchronous FIFO read by the host. It replaces the bare receiver wherever a host cannot service every byte immediately.

Parameters:
BAUD_DIV, 27, clk cycles per oversample tick (baud = f_clk / (16*BAUD_DIV)); must be >= 1
FIFO_DEPTH, 8, FIFO entries; must be a power of two, >= 2
CNT_W, $clog2(FIFO_DEPTH)+1, width of the count output (derived)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
rx  input  1  serial line, idle high, asynchronous to clk
rd_en  input  1  pop head entry; ignored when empty
data_out  output  8  FIFO head (first-word fall-through); valid while empty=0
empty  output  1  FIFO holds no bytes
full  output  1  FIFO holds FIFO_DEPTH bytes
count  output  CNT_W  number of bytes held
frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded
overrun  output  1  one-cycle pulse: byte completed while FIFO full, byte dropped

Behaviour:
- Reset, asynchronous: FSM=IDLE; synchronizer flops=1; tick and sample counters=0; FIFO pointers=0; data_out=0, empty=1, full=0, count=0, frame_err=0, overrun=0.
- rx passes through a 2-FF synchronizer (rx_s); all decisions use rx_s only.
- Tick counter counts 0..BAUD_DIV-1; os_tick is asserted for one clk when the count wraps. The counter is free-running.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled).
- IDLE: when rx_s=0 is seen, clear the sample counter and go to START.
- START: on the os_tick where the sample count is 7 (mid-bit), check rx_s. If rx_s=0, clear the sample count, clear the bit index, and go to DATA. If rx_s=1, treat it as a false start and return to IDLE.
- DATA: on every 16th os_tick, sample rx_s into the shift register, LSB first. After bit index 7, go to STOP (or PARITY).
- STOP: sample at mid-bit.
  - rx_s=1: push the byte and return to IDLE in the same cycle. Returning at mid-stop allows back-to-back frames.
  - rx_s=0: pulse frame_err, do not push, and go to IDLE. IDLE then waits for rx_s=1 before arming for a new start bit.
- Push with full=0 and no pop: count+1.
- Push with full=1 and rd_en=0: pulse overrun, drop the new byte, leave FIFO contents unchanged.
- Push and rd_en in the same cycle: both succeed, count unchanged. This includes the full case, where no overrun is flagged.
- rd_en with empty=1 is ignored; pointers and count are unchanged.
- data_out updates the cycle after a pop or after a push into an empty FIFO. Latency from the mid-stop sample to empty=0 is 1 clk.
- Pointers wrap modulo FIFO_DEPTH. full and empty are derived from count.
- Reset mid-frame aborts the frame and flushes the FIFO. No pulses are emitted.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - PARITY state is inserted between DATA and STOP and samples one even-parity bit at mid-bit.
  - Adds output port parity_err (1 bit, reset 0). It pulses for one cycle when (^data ^ parity_bit) != 0, and the byte is discarded.
  - When both parity and framing fail, only frame_err pulses.
- Undefined: there is no PARITY state and no parity_err port; the frame is 10 bits.

Decomposition:
- Package uart_pkg holds:
  - typedef enum rx_state_e {IDLE, START, DATA, PARITY, STOP}
  - localparams OVERSAMPLE=16, MID_SAMPLE=7, DATA_BITS=8
- One sub-module: uart_sync_fifo, parameterised on width and depth, with push/pop/full/empty/count.
- The synchronizer, tick counter, and FSM stay in the top module.

Test Plan:
- Sim settings: BAUD_DIV=2, FIFO_DEPTH=4, so 32 clk per bit.
- Frame 0xA5, stop=1 -> empty falls; data_out=8'hA5; count=1; no error pulses. Then rd_en for 1 cycle -> empty=1, count=0.
- rx low for 5 os_ticks, then high (glitch) -> FSM returns to IDLE; count stays 0; no pulses.
- Frame 0x3C with stop=0 -> frame_err pulses exactly 1 cycle; count=0. A following valid 0x81 frame is received correctly.
- 5 back-to-back frames 0x01..0x05 with no reads -> overrun pulses once (on 0x05); full=1. Reads return 01, 02, 03, 04, then empty=1.
- Full FIFO, rd_en asserted in the same cycle as the 0x77 push -> no overrun; count stays 4; 0x77 is read last.
- rst asserted mid-DATA of 0x55 with 2 bytes buffered -> immediate empty=1, count=0. After release, a 0x99 frame is received correctly.
- With UART_RX_PARITY_EN defined: 0x07 sent with parity bit 0 -> parity_err pulses and the byte is dropped. 0x07 sent with parity bit 1 -> the byte is accepted.
